// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared FSM encodings, default sizes and the level-to-mask helper for hazard logic
package pipe_hazard_ctrl_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;
  localparam int DEF_NSTAGE = 6;
  localparam int DEF_LW = 3;
  function automatic logic [31:0] lvl_mask(input int unsigned lvl, input int unsigned n);
    return (lvl >= n) ? '1 : (32'd2 << lvl) - 32'd1;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_hold_counter.sv
// pipe_hazard_ctrl_hold_counter: hold duration counter (CLK, RST, load/len, dec, clr -> zero)
module pipe_hazard_ctrl_hold_counter #(
  parameter int CW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic          dec,
  input  logic          clr,
  input  logic [CW-1:0] len,
  output logic          zero
);
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK)
    if (RST || clr) cnt <= '0;
    else if (load) cnt <= len - CW'(1);
    else if (dec && cnt != '0) cnt <= cnt - CW'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller (CLK, RST, stall_req, hold_start/hold_len, flush_req/flush_level -> stall, flush, busy; PIPE_CTRL_STATS_EN adds stall_cycles, hold_cycles, flush_count)
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int                 NSTAGE     = DEF_NSTAGE,
  parameter int                 NREQ       = 2,
  parameter int                 LW         = DEF_LW,
  parameter logic [NREQ*LW-1:0] REQ_LEVEL  = {3'd3, 3'd2},
  parameter int                 HOLD_LEVEL = 3,
  parameter int                 CW         = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              hold_start,
  input  logic [CW-1:0]     hold_len,
  input  logic              flush_req,
  input  logic [LW-1:0]     flush_level,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              busy
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       hold_cycles,
  output logic [15:0]       flush_count
`endif
);
  state_t state, nxt;
  logic cnt_zero, start;
  logic [NSTAGE-1:0] req_or;
  assign start = state == ST_IDLE && hold_start && hold_len != '0 && !flush_req;
  pipe_hazard_ctrl_hold_counter #(.CW(CW)) u_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .load (start),
    .dec  (state == ST_HOLD),
    .clr  (flush_req),
    .len  (hold_len),
    .zero (cnt_zero)
  );
  always_ff @(posedge CLK)
    if (RST) state <= ST_IDLE;
    else state <= nxt;
  always_comb begin
    req_or = '0;
    for (int i = 0; i < NREQ; i++)
      req_or |= stall_req[i] ? NSTAGE'(lvl_mask(32'(REQ_LEVEL[i*LW +: LW]), NSTAGE)) : '0;
  end
  // Flush overrides everything, including the hold; reset blanks all outputs.
  always_comb begin
    nxt = flush_req ? ST_IDLE : state == ST_IDLE ? (start ? ST_HOLD : ST_IDLE) : (cnt_zero ? ST_IDLE : ST_HOLD);
    busy = !RST && state == ST_HOLD;
    stall = (RST || flush_req) ? '0 : req_or | (busy ? NSTAGE'(lvl_mask(HOLD_LEVEL, NSTAGE)) : '0);
    flush = (!RST && flush_req) ? NSTAGE'(lvl_mask(32'(flush_level), NSTAGE)) : '0;
  end
`ifdef PIPE_CTRL_STATS_EN
  always_ff @(posedge CLK)
    if (RST) begin
      stall_cycles <= '0;
      hold_cycles  <= '0;
      flush_count  <= '0;
    end else begin
      if (stall != '0 && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (state == ST_HOLD && hold_cycles != '1) hold_cycles <= hold_cycles + 32'd1;
      if (flush_req && flush_count != '1) flush_count <= flush_count + 16'd1;
    end
`endif
endmodule
